serial_parity_checker: RTL and testbench
========================================

// Module: serial_parity_checker
// PURPOSE
//   Receive end of the parity-protected link: deserialises a bit-serial frame
//   of DATA_W data bits (LSB first) plus one trailing parity bit, then presents
//   the recovered word with a one-cycle valid strobe. Checks even or odd parity
//   and flags mismatches. Sits between the serial line sampler and word-level logic.
// PARAMETERS
//   DATA_W   4   data bits per frame (>=2); parity bit not included
//   CNT_W    8   width of parity-error counter (used only with PARITY_ERR_CNT_EN)
// PORTS
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous, active-high reset
//   odd_sel      in   1        0 = even parity, 1 = odd parity; sampled at frame start
//   bit_valid    in   1        strobe: bit_in is a valid line bit this cycle
//   bit_in       in   1        serial data/parity bit
//   abort        in   1        synchronous frame discard
//   err_cnt_clr  in   1        synchronous clear of err_count
//   busy         out  1        frame in progress (state != IDLE)
//   data_out     out  DATA_W   recovered word; held until next frame completes
//   data_valid   out  1        one-cycle strobe: data_out/parity_err updated
//   parity_err   out  1        parity mismatch for the frame just completed
//   err_count    out  CNT_W    saturating count of frames with parity_err
// BEHAVIOUR
//   Reset (async, any time incl. mid-frame): state=IDLE, shift reg=0, bit count=0,
//     data_out=0, data_valid=0, parity_err=0, busy=0, err_count=0.
//   FSM states: IDLE, DATA, PAR.
//   - IDLE: bit_valid=1 -> shift in bit 0, latch odd_sel, bit count=1, go DATA.
//   - DATA: each bit_valid shifts next bit into position [count]; after bit
//     DATA_W-1 is taken, go PAR. Cycles with bit_valid=0 hold state (gaps allowed).
//   - PAR: bit_valid=1 samples parity bit p; next cycle: data_out=word,
//     data_valid=1 for exactly one cycle, parity_err registered, go IDLE.
//   Parity rule: even mode -> err = ^{word,p}; odd mode -> err = ~^{word,p}
//     (valid even frame has even number of ones across data+parity).
//   Latency: data_valid rises 1 clk after the parity bit's bit_valid cycle.
//   A bit_valid in the cycle data_valid is high is accepted as a new frame's bit 0.
//   abort=1: return to IDLE, discard partial frame, no data_valid, data_out and
//     parity_err unchanged; abort wins over a simultaneous bit_valid (bit dropped).
//   abort in IDLE: no effect.
//   odd_sel changes mid-frame are ignored; the latched value applies.
//   parity_err holds its value until the next completed frame.
// CONFIGURATION
//   PARITY_ERR_CNT_EN defined: err_count increments by 1 in the cycle data_valid
//     and parity_err are both high; saturates at 2**CNT_W-1 (no wrap);
//     err_cnt_clr clears it, and wins over a simultaneous increment.
//   PARITY_ERR_CNT_EN undefined: no counter logic; err_count tied to 0,
//     err_cnt_clr ignored. All other behaviour is identical.
// TESTING (DATA_W=4)
//   Even mode, bits 1,1,0,1 then p=1 -> data_out=4'b1011, data_valid 1 clk, parity_err=0.
//   Even mode, bits 1,1,0,1 then p=0 -> data_out=4'b1011, parity_err=1, err_count +1 (EN).
//   odd_sel=1, bits 0,0,0,0, p=1 -> data_out=4'b0000, err=0; with p=0 -> err=1.
//   2 bits, then abort with bit_valid=1; new frame 0,1,1,0,p=0 -> 4'b0110, err=0.
//   rst pulse after 3 bits -> all outputs 0, busy=0; next full frame decodes correctly.
//   EN, CNT_W=2: 5 bad frames -> err_count=3 (saturated); err_cnt_clr -> 0.

Source files
------------

// File: rtl/serial_parity_checker_if.sv
// serial_parity_checker_if
//   Bundles the line-side inputs and word-side outputs of the serial parity
//   checker. Configuration macro honoured by the checker: PARITY_ERR_CNT_EN.
//   Parameters DATA_W / CNT_W must match those of the attached checker.
//   Signals:
//     odd_sel      0 = even parity, 1 = odd parity (latched at frame start)
//     bit_valid    bit_in carries a valid line bit this cycle
//     bit_in       serial data / parity bit, LSB first
//     abort        discard the frame in progress
//     err_cnt_clr  clear the parity-error counter
//     busy         frame in progress
//     data_out     recovered word, held until the next completed frame
//     data_valid   one-cycle strobe, data_out / parity_err just updated
//     parity_err   parity mismatch of the last completed frame
//     err_count    saturating count of frames with a parity error
//   Modports: master drives the line side, slave is the checker.
interface serial_parity_checker_if #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
);
   logic              odd_sel;
   logic              bit_valid;
   logic              bit_in;
   logic              abort;
   logic              err_cnt_clr;
   logic              busy;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic [CNT_W-1:0]  err_count;

   modport master (
      output odd_sel, bit_valid, bit_in, abort, err_cnt_clr,
      input  busy, data_out, data_valid, parity_err, err_count
   );

   modport slave (
      input  odd_sel, bit_valid, bit_in, abort, err_cnt_clr,
      output busy, data_out, data_valid, parity_err, err_count
   );
endinterface

// File: rtl/serial_parity_checker.sv
// serial_parity_checker
//   Receive end of a parity-protected serial link. Collects DATA_W data bits
//   (LSB first) followed by one parity bit, then presents the word with a
//   one-cycle data_valid strobe and a registered parity_err flag.
//   Optional feature macro: PARITY_ERR_CNT_EN -- when defined, err_count is a
//   saturating count of bad frames cleared by err_cnt_clr; otherwise
//   err_count is tied to zero and err_cnt_clr is ignored.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   serial_parity_checker_if.slave (see interface header)
module serial_parity_checker #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   serial_parity_checker_if.slave bus
);
   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_PAR  = 2'd2;

   logic [1:0]        state_reg;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_next;
   logic [CW-1:0]     bit_cnt_reg;
   logic              odd_reg;
   logic [DATA_W-1:0] data_out_reg;
   logic              data_valid_reg;
   logic              parity_err_reg;

   // abort beats a simultaneous bit, so a bit is only taken without abort
   logic take;
   logic start_take;
   logic data_take;
   logic par_take;

   assign take       = bus.bit_valid && !bus.abort;
   assign start_take = take && (state_reg == ST_IDLE);
   assign data_take  = take && (state_reg == ST_DATA);
   assign par_take   = take && (state_reg == ST_PAR);

   // Per-lane shift register update: a new frame clears the word and places
   // bit 0; later bits land directly at the position given by the bit count.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_lane
         assign shift_next[gi] =
            start_take ? ((gi == 0) ? bus.bit_in : 1'b0) :
            (data_take && (bit_cnt_reg == CW'(gi))) ? bus.bit_in :
            shift_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         shift_reg      <= '0;
         bit_cnt_reg    <= '0;
         odd_reg        <= 1'b0;
         data_out_reg   <= '0;
         data_valid_reg <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         shift_reg      <= shift_next;
         data_valid_reg <= 1'b0;
         if (bus.abort) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (start_take) begin
                     odd_reg     <= bus.odd_sel;
                     bit_cnt_reg <= CW'(1);
                     state_reg   <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (data_take) begin
                     if (bit_cnt_reg == LAST_IDX) begin
                        state_reg <= ST_PAR;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                     end
                  end
               end
               ST_PAR: begin
                  if (par_take) begin
                     data_out_reg   <= shift_reg;
                     // even: error on odd ones count; odd mode inverts it
                     parity_err_reg <= (^{shift_reg, bus.bit_in}) ^ odd_reg;
                     data_valid_reg <= 1'b1;
                     bit_cnt_reg    <= '0;
                     state_reg      <= ST_IDLE;
                  end
               end
               default: begin
                  state_reg   <= ST_IDLE;
                  bit_cnt_reg <= '0;
               end
            endcase
         end
      end
   end

   assign bus.busy       = (state_reg != ST_IDLE);
   assign bus.data_out   = data_out_reg;
   assign bus.data_valid = data_valid_reg;
   assign bus.parity_err = parity_err_reg;

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_count_reg;

   // counts on the strobe cycle itself; clear has priority, no wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_reg <= '0;
      end else if (bus.err_cnt_clr) begin
         err_count_reg <= '0;
      end else if (data_valid_reg && parity_err_reg &&
                   (err_count_reg != {CNT_W{1'b1}})) begin
         err_count_reg <= err_count_reg + CNT_W'(1);
      end
   end

   assign bus.err_count = err_count_reg;
`else
   assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker
//   Directed bench for serial_parity_checker with DATA_W=4, CNT_W=2.
//   Expected words and parity flags are hand-computed per frame; the error
//   count expectation follows the PARITY_ERR_CNT_EN setting of the build.
module tb_serial_parity_checker;
   localparam int DATA_W  = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_parity_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   serial_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef PARITY_ERR_CNT_EN
   bit cnt_en = 1'b1;
`else
   bit cnt_en = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int exp_cnt  = 0;
   logic [3:0] last_word = 4'h0;
   logic       last_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      tick();
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
   endtask

   // gap idle cycles after each data bit; flip toggles odd_sel after bit 0
   task automatic send_frame(input logic odd, input logic [3:0] w, input logic p,
                             input int gap, input bit flip);
      bus.odd_sel = odd;
      for (int i = 0; i < 4; i++) begin
         send_bit(w[i]);
         if (i == 0 && flip) bus.odd_sel = ~odd;
         repeat (gap) tick();
      end
      send_bit(p);
   endtask

   // called #1 after the parity-bit edge: strobe cycle
   task automatic check_result(input string tag, input logic [3:0] w, input logic err);
      check({tag, ".valid"}, 32'(bus.data_valid), 32'd1);
      check({tag, ".data"},  32'(bus.data_out),   32'(w));
      check({tag, ".perr"},  32'(bus.parity_err), 32'(err));
      check({tag, ".busy"},  32'(bus.busy),       32'd0);
      if (err && cnt_en && exp_cnt < CNT_MAX) exp_cnt++;
      last_word = w;
      last_err  = err;
      $display("frame %s: data_out=%b parity_err=%0b", tag, bus.data_out, bus.parity_err);
   endtask

   task automatic run_frame(input string tag, input logic odd, input logic [3:0] w,
                            input logic p, input logic err, input int gap, input bit flip);
      send_frame(odd, w, p, gap, flip);
      check_result(tag, w, err);
      tick();
      check({tag, ".strobe_end"}, 32'(bus.data_valid), 32'd0);
      check({tag, ".hold"},       32'(bus.data_out),   32'(last_word));
      check({tag, ".cnt"},        32'(bus.err_count),  32'(exp_cnt));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.odd_sel = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      bus.abort = 1'b0;   bus.err_cnt_clr = 1'b0;
      #1;
      check("rst.busy",  32'(bus.busy),       32'd0);
      check("rst.data",  32'(bus.data_out),   32'd0);
      check("rst.valid", 32'(bus.data_valid), 32'd0);
      check("rst.perr",  32'(bus.parity_err), 32'd0);
      check("rst.cnt",   32'(bus.err_count),  32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // basic even / odd frames; ones counts: 1011+1 =4, 1011+0 =3, 0000+1 =1
      run_frame("even_ok",  1'b0, 4'b1011, 1'b1, 1'b0, 0, 1'b0);
      run_frame("even_bad", 1'b0, 4'b1011, 1'b0, 1'b1, 0, 1'b0);
      run_frame("odd_ok",   1'b1, 4'b0000, 1'b1, 1'b0, 0, 1'b0);
      run_frame("odd_bad",  1'b1, 4'b0000, 1'b0, 1'b1, 0, 1'b0);

      // gaps between bits; busy must stay high across them
      bus.odd_sel = 1'b1;
      send_bit(1'b0);
      tick();
      check("gap.busy", 32'(bus.busy), 32'd1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      tick();
      send_bit(1'b0);   // 1110 + 0 -> three ones, fine in odd mode
      check_result("gap", 4'b1110, 1'b0);
      tick();

      // odd_sel flipped after bit 0: even latched, 0110+1 -> error
      run_frame("latch_odd", 1'b0, 4'b0110, 1'b1, 1'b1, 1, 1'b1);

      // abort with a simultaneous bit after two bits
      bus.odd_sel = 1'b0;
      send_bit(1'b1); send_bit(1'b0);
      bus.abort = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
      tick();
      bus.abort = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      check("abort.busy",  32'(bus.busy),       32'd0);
      check("abort.valid", 32'(bus.data_valid), 32'd0);
      check("abort.data",  32'(bus.data_out),   32'(last_word));
      check("abort.perr",  32'(bus.parity_err), 32'(last_err));
      $display("abort after 2 bits: busy=%0b", bus.busy);
      run_frame("post_abort", 1'b0, 4'b0110, 1'b0, 1'b0, 0, 1'b0);

      // abort in the parity state, parity bit presented alongside
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      check("par_state.busy", 32'(bus.busy), 32'd1);
      bus.abort = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
      tick();
      bus.abort = 1'b0; bus.bit_valid = 1'b0;
      check("abort_par.busy", 32'(bus.busy), 32'd0);
      tick();
      check("abort_par.valid", 32'(bus.data_valid), 32'd0);
      check("abort_par.data",  32'(bus.data_out),   32'(last_word));
      $display("abort in parity state: data_valid=%0b", bus.data_valid);

      // abort while idle does nothing
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_idle.busy", 32'(bus.busy), 32'd0);
      run_frame("idle_abort", 1'b0, 4'b1111, 1'b0, 1'b0, 0, 1'b0);

      // back-to-back: second frame's bit 0 arrives during the strobe cycle
      send_frame(1'b0, 4'b0101, 1'b0, 0, 1'b0);
      check_result("b2b_a", 4'b0101, 1'b0);
      send_frame(1'b0, 4'b1000, 1'b0, 0, 1'b0);
      check_result("b2b_b", 4'b1000, 1'b1);
      tick();
      check("b2b_b.strobe_end", 32'(bus.data_valid), 32'd0);
      check("b2b_b.cnt",        32'(bus.err_count),  32'(exp_cnt));

      // asynchronous reset after three bits
      bus.odd_sel = 1'b0;
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst.busy", 32'(bus.busy),       32'd0);
      check("mid_rst.data", 32'(bus.data_out),   32'd0);
      check("mid_rst.perr", 32'(bus.parity_err), 32'd0);
      check("mid_rst.cnt",  32'(bus.err_count),  32'd0);
      $display("reset mid-frame: busy=%0b data_out=%b", bus.busy, bus.data_out);
      exp_cnt = 0; last_word = 4'h0; last_err = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      run_frame("post_rst", 1'b0, 4'b1011, 1'b1, 1'b0, 0, 1'b0);

      // saturation: five bad frames with a 2-bit counter
      for (int k = 0; k < 5; k++) begin
         run_frame($sformatf("sat%0d", k), 1'b0, 4'b1011, 1'b0, 1'b1, 0, 1'b0);
      end
      check("sat.cnt", 32'(bus.err_count), 32'(cnt_en ? CNT_MAX : 0));
      bus.err_cnt_clr = 1'b1;
      tick();
      bus.err_cnt_clr = 1'b0;
      exp_cnt = 0;
      check("clr.cnt", 32'(bus.err_count), 32'(exp_cnt));
      $display("err_cnt_clr: err_count=%0d", bus.err_count);

      // one bad frame counted, then clear coincident with the next bad strobe
      run_frame("pre_clr", 1'b0, 4'b1011, 1'b0, 1'b1, 0, 1'b0);
      send_frame(1'b0, 4'b1011, 1'b0, 0, 1'b0);
      check_result("clr_race", 4'b1011, 1'b1);
      bus.err_cnt_clr = 1'b1;
      tick();
      bus.err_cnt_clr = 1'b0;
      exp_cnt = 0;
      check("clr_race.cnt", 32'(bus.err_count), 32'(exp_cnt));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
